// File: rtl/rv32i_wb_core_pkg.sv
// Shared types and constants for the multicycle RV32I Wishbone core.
// Opcodes, access-size codes, FSM states, ALU operations and small helpers.
package rv32i_wb_core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] SEL_BYTE = 3'b000;
    localparam logic [2:0] SEL_HALF = 3'b001;
    localparam logic [2:0] SEL_WORD = 3'b010;

    typedef enum logic [2:0] {
        FETCH, FETCH_WAIT, EXECUTE, MEM, MEM_WAIT, WRITEBACK
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // funct7[5] only selects SUB for register-register ops; SRA/SRAI share it
    function automatic alu_op_t alu_decode(input logic [2:0] f3,
                                           input logic alt,
                                           input logic is_op);
        case (f3)
            3'b000:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'h0, d[7:0]};
            3'b101:  return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_wb_core_if.sv
// Pipelined-Wishbone master port of the core plus run enable and retire strobe.
// Names are from the core's point of view (i_ = into core, o_ = out of core).
interface rv32i_wb_core_if;
    logic        i_wb_stb;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;
    logic [31:0] o_wb_data;
    logic [31:0] o_wb_addr;
    logic        o_wb_we;
    logic        o_wb_stb;
    logic [2:0]  o_wb_sel;
    logic        o_wb_ack;

    modport master (
        input  i_wb_stb, i_wb_ack, i_wb_stall, i_wb_data,
        output o_wb_data, o_wb_addr, o_wb_we, o_wb_stb, o_wb_sel, o_wb_ack
    );

    modport slave (
        output i_wb_stb, i_wb_ack, i_wb_stall, i_wb_data,
        input  o_wb_data, o_wb_addr, o_wb_we, o_wb_stb, o_wb_sel, o_wb_ack
    );
endinterface

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU with compare flags for branch resolution.
module rv32i_alu
    import rv32i_wb_core_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'h0, lt};
            ALU_SLTU: y = {31'h0, ltu};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            default:  y = a & b;
        endcase
    end

endmodule

// File: rtl/rv32i_wb_core.sv
// Multicycle RV32I core: one instruction at a time over a single
// pipelined-Wishbone port shared by fetch and data access.
module rv32i_wb_core
    import rv32i_wb_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    rv32i_wb_core_if.master  bus
);

    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, ir_q, res_q, npc_q;
    logic [XLEN-1:0] regs [1:31];
    logic            wr_q;

    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [2:0]  sel_q, sel_d;
    logic        stb_q, stb_d, we_q, we_d, ack_q, ack_d;

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, alu_b, alu_y, pc4, mem_addr;
    logic [31:0] res_x, npc_x;
    logic        wr_x, eq, lt, ltu, take;
    logic        is_load, is_store, is_op, is_branch;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'h0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_op     = (opc == OPC_OP);
    assign is_branch = (opc == OPC_BRANCH);

    assign rs1_v    = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_v    = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign alu_b    = (is_op || is_branch) ? rs2_v : imm_i;
    assign pc4      = pc_q + 32'd4;
    assign mem_addr = rs1_v + (is_store ? imm_s : imm_i);

    rv32i_alu u_alu (
        .op  (alu_decode(f3, ir_q[30], is_op)),
        .a   (rs1_v),
        .b   (alu_b),
        .y   (alu_y),
        .eq  (eq),
        .lt  (lt),
        .ltu (ltu)
    );

    always_comb begin
        case (f3)
            3'b000:  take = eq;
            3'b001:  take = !eq;
            3'b100:  take = lt;
            3'b101:  take = !lt;
            3'b110:  take = ltu;
            3'b111:  take = !ltu;
            default: take = 1'b0;
        endcase
    end

    // Unlisted opcodes (FENCE, SYSTEM, unknown) fall through as pc+4, no write
    always_comb begin
        res_x = alu_y;
        npc_x = pc4;
        wr_x  = 1'b0;
        case (opc)
            OPC_LUI:    begin res_x = imm_u;        wr_x = 1'b1; end
            OPC_AUIPC:  begin res_x = pc_q + imm_u; wr_x = 1'b1; end
            OPC_JAL: begin
                res_x = pc4;
                npc_x = pc_q + imm_j;
                wr_x  = 1'b1;
            end
            OPC_JALR: begin
                res_x = pc4;
                npc_x = (rs1_v + imm_i) & ~32'h1;
                wr_x  = 1'b1;
            end
            OPC_BRANCH: npc_x = take ? pc_q + imm_b : pc4;
            OPC_LOAD:   wr_x = 1'b1;
            OPC_OPIMM,
            OPC_OP:     wr_x = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (stb_q) begin
                    if (!bus.i_wb_stall) begin
                        stb_d   = 1'b0;
                        state_d = FETCH_WAIT;
                    end
                end else if (bus.i_wb_stb) begin
                    stb_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                    sel_d  = SEL_WORD;
                end
            end
            FETCH_WAIT: if (bus.i_wb_ack) state_d = EXECUTE;
            EXECUTE: begin
                if (is_load || is_store) begin
                    state_d = MEM;
                    stb_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = mem_addr;
                    sel_d   = {1'b0, f3[1:0]};
                    if (is_store) data_d = rs2_v;
                end else begin
                    state_d = WRITEBACK;
                    ack_d   = 1'b1;
                end
            end
            MEM: begin
                if (!bus.i_wb_stall) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.i_wb_ack) begin
                    state_d = WRITEBACK;
                    ack_d   = 1'b1;
                end
            end
            WRITEBACK: begin
                state_d = FETCH;
                // Issue the next fetch straight away to keep ALU ops at 4 cycles
                if (bus.i_wb_stb) begin
                    stb_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = npc_q;
                    sel_d  = SEL_WORD;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q   <= RESET_PC;
            ir_q   <= '0;
            res_q  <= '0;
            npc_q  <= '0;
            wr_q   <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            ack_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= SEL_WORD;
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            stb_q  <= stb_d;
            we_q   <= we_d;
            ack_q  <= ack_d;
            addr_q <= addr_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            if (state_q == FETCH_WAIT && bus.i_wb_ack) ir_q <= bus.i_wb_data;
            if (state_q == EXECUTE) begin
                res_q <= res_x;
                npc_q <= npc_x;
                wr_q  <= wr_x;
            end
            if (state_q == MEM_WAIT && bus.i_wb_ack && is_load)
                res_q <= load_ext(f3, bus.i_wb_data);
            if (state_q == WRITEBACK) begin
                pc_q <= npc_q;
                if (wr_q && rd != 5'd0) regs[rd] <= res_q;
            end
        end
    end

    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = we_q;
    assign bus.o_wb_addr = addr_q;
    assign bus.o_wb_data = data_q;
    assign bus.o_wb_sel  = sel_q;
    assign bus.o_wb_ack  = ack_q;

endmodule

// File: tb/tb_rv32i_wb_core.sv
// Bench for rv32i_wb_core: small programs in a Wishbone memory model,
// stores checked against a scoreboard of expected bus writes.
module tb_rv32i_wb_core;
    import rv32i_wb_core_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string           name;
        logic [7:0][31:0] prog;
        logic [31:0]     ea;
        logic [31:0]     ed;
        logic [2:0]      es;
        int              nret;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
        logic [31:0] acks;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem [0:1023];

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int acc_cnt = 0;
    obs_t obs_q [$];
    obs_t exp_q [$];
    vec_t vecs [$];

    rv32i_wb_core_if bus ();

    rv32i_wb_core dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_mem(input logic [31:0] a,
                                           input logic [2:0] s);
        logic [9:0] i;
        i = a[9:0];
        case (s)
            3'b000:  return {24'h0, mem[i]};
            3'b001:  return {16'h0, mem[i + 10'd1], mem[i]};
            default: return {mem[i + 10'd3], mem[i + 10'd2],
                             mem[i + 10'd1], mem[i]};
        endcase
    endfunction

    // Slave: accepts when stb && !stall, acks one cycle later
    always @(posedge clk) begin
        bus.i_wb_ack <= 1'b0;
        if (rst_n && bus.o_wb_stb && !bus.i_wb_stall) begin
            bus.i_wb_ack  <= 1'b1;
            bus.i_wb_data <= rd_mem(bus.o_wb_addr, bus.o_wb_sel);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_wb_ack) ack_cnt++;
            if (bus.o_wb_stb && !bus.i_wb_stall) begin
                acc_cnt++;
                if (bus.o_wb_we)
                    obs_q.push_back({bus.o_wb_addr, bus.o_wb_data,
                                     bus.o_wb_sel, 32'(ack_cnt)});
            end
        end
    end

    function automatic logic [31:0] ei(input logic [6:0] op, input int f3,
                                       input int rd, input int rs1,
                                       input int imm);
        logic [31:0] m, f, d, a;
        m = imm; f = f3; d = rd; a = rs1;
        return {m[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] es(input int f3, input int rs2,
                                       input int rs1, input int imm);
        logic [31:0] m, f, b, a;
        m = imm; f = f3; b = rs2; a = rs1;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] er(input int f7, input int f3,
                                       input int rd, input int rs1,
                                       input int rs2);
        logic [31:0] s, f, d, a, b;
        s = f7; f = f3; d = rd; a = rs1; b = rs2;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], OPC_OP};
    endfunction

    function automatic logic [31:0] eb(input int f3, input int rs1,
                                       input int rs2, input int imm);
        logic [31:0] m, f, a, b;
        m = imm; f = f3; a = rs1; b = rs2;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0],
                m[4:1], m[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] ej(input int rd, input int imm);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], OPC_JAL};
    endfunction

    function automatic logic [31:0] eu(input logic [6:0] op, input int rd,
                                       input int imm20);
        logic [31:0] m, d;
        m = imm20; d = rd;
        return {m[19:0], d[4:0], op};
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [31:0] ea,
                       input logic [31:0] ed, input logic [2:0] s,
                       input int nr, input logic [31:0] w0,
                       input logic [31:0] w1 = NOP,
                       input logic [31:0] w2 = NOP,
                       input logic [31:0] w3 = NOP,
                       input logic [31:0] w4 = NOP,
                       input logic [31:0] w5 = NOP,
                       input logic [31:0] w6 = NOP,
                       input logic [31:0] w7 = NOP);
        vec_t v;
        v.name = n;
        v.prog = {w7, w6, w5, w4, w3, w2, w1, w0};
        v.ea = ea; v.ed = ed; v.es = s; v.nret = nr;
        vecs.push_back(v);
    endtask

    task automatic load_mem(input vec_t v);
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h0;
        mem[10'h200] = 8'h80;
        mem[10'h202] = 8'h34;
        mem[10'h203] = 8'h92;
        {mem[10'h207], mem[10'h206], mem[10'h205], mem[10'h204]} = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) begin
            w = v.prog[k];
            {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]} = w;
        end
    endtask

    task automatic reset_release(input vec_t v, input logic st);
        rst_n = 1'b0;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_stall = st;
        load_mem(v);
        repeat (2) @(posedge clk);
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_check(input vec_t v);
        int base, cyc;
        obs_t o, e;
        base = ack_cnt;
        exp_q.push_back({v.ea, v.ed, v.es, 32'(v.nret)});
        cyc = 0;
        while (obs_q.size() == 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " store_seen"}, 32'(obs_q.size()), 32'd1);
        if (obs_q.size() != 0) begin
            bus.i_wb_stb = 1'b0;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({v.name, " addr"}, o.addr, e.addr);
            chk({v.name, " data"}, o.data, e.data);
            chk({v.name, " sel"}, 32'(o.sel), 32'(e.sel));
            chk({v.name, " retired_before"}, o.acks - 32'(base), e.acks);
            repeat (8) @(posedge clk);
            #1;
            chk({v.name, " retired_total"}, 32'(ack_cnt - base), e.acks + 1);
            chk({v.name, " idle_stb"}, 32'(bus.o_wb_stb), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vec_t vd;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack = 1'b0;
        bus.i_wb_data = '0;

        add("addi_sw", 32'h100, 32'h2, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 1, 0, 5), ei(OPC_OPIMM, 0, 2, 1, -3),
            es(2, 2, 0, 32'h100));
        add("lb_sext", 32'h104, 32'hFFFF_FF80, SEL_WORD, 1,
            ei(OPC_LOAD, 0, 3, 0, 32'h200), es(2, 3, 0, 32'h104));
        add("lbu", 32'h104, 32'h0000_0080, SEL_WORD, 1,
            ei(OPC_LOAD, 4, 3, 0, 32'h200), es(2, 3, 0, 32'h104));
        add("lh_sext", 32'h104, 32'hFFFF_9234, SEL_WORD, 1,
            ei(OPC_LOAD, 1, 3, 0, 32'h202), es(2, 3, 0, 32'h104));
        add("lw", 32'h104, 32'hDEAD_BEEF, SEL_WORD, 1,
            ei(OPC_LOAD, 2, 3, 0, 32'h204), es(2, 3, 0, 32'h104));
        add("x0_write", 32'h108, 32'h0, SEL_WORD, 1,
            ei(OPC_OPIMM, 0, 0, 0, 7), es(2, 0, 0, 32'h108));
        add("srai", 32'h10C, 32'hF800_0000, SEL_WORD, 2,
            eu(OPC_LUI, 1, 32'h80000), ei(OPC_OPIMM, 5, 2, 1, 32'h404),
            es(2, 2, 0, 32'h10C));
        add("srli", 32'h10C, 32'h0800_0000, SEL_WORD, 2,
            eu(OPC_LUI, 1, 32'h80000), ei(OPC_OPIMM, 5, 2, 1, 4),
            es(2, 2, 0, 32'h10C));
        add("sub", 32'h10C, 32'hFFFF_FFFE, SEL_WORD, 3,
            ei(OPC_OPIMM, 0, 1, 0, 3), ei(OPC_OPIMM, 0, 2, 0, 5),
            er(32, 0, 3, 1, 2), es(2, 3, 0, 32'h10C));
        add("slt", 32'h10C, 32'h1, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 1, 0, -1), er(0, 2, 2, 1, 0),
            es(2, 2, 0, 32'h10C));
        add("sltu", 32'h10C, 32'h1, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 1, 0, -1), er(0, 3, 2, 0, 1),
            es(2, 2, 0, 32'h10C));
        add("sb", 32'h10E, 32'h0000_07AB, SEL_BYTE, 1,
            ei(OPC_OPIMM, 0, 1, 0, 32'h7AB), es(0, 1, 0, 32'h10E));
        add("sh", 32'h112, 32'hFFFF_FFFE, SEL_HALF, 1,
            ei(OPC_OPIMM, 0, 1, 0, -2), es(1, 1, 0, 32'h112));
        add("auipc", 32'h114, 32'h0000_1004, SEL_WORD, 2,
            NOP, eu(OPC_AUIPC, 1, 1), es(2, 1, 0, 32'h114));
        add("jal", 32'h118, 32'h14, SEL_WORD, 2,
            ej(0, 16), NOP, NOP, NOP, ej(1, 8),
            es(2, 0, 0, 32'h118), es(2, 1, 0, 32'h118));
        add("beq_taken", 32'h11C, 32'h1, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 1, 0, 1), eb(0, 1, 1, 8),
            es(2, 0, 0, 32'h11C), es(2, 1, 0, 32'h11C));
        add("beq_not", 32'h11C, 32'h2, SEL_WORD, 3,
            ei(OPC_OPIMM, 0, 1, 0, 1), eb(0, 1, 0, 8),
            ei(OPC_OPIMM, 0, 1, 0, 2), es(2, 1, 0, 32'h11C));
        add("jalr", 32'h120, 32'h8, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 5, 0, 32'h11), ei(OPC_JALR, 0, 1, 5, 0),
            es(2, 0, 0, 32'h120), NOP, es(2, 1, 0, 32'h120));
        add("bge_signed", 32'h124, 32'h5, SEL_WORD, 3,
            ei(OPC_OPIMM, 0, 1, 0, -1), eb(5, 1, 0, 8),
            ei(OPC_OPIMM, 0, 1, 0, 5), es(2, 1, 0, 32'h124));
        add("bltu", 32'h124, 32'hFFFF_FFFF, SEL_WORD, 2,
            ei(OPC_OPIMM, 0, 1, 0, -1), eb(6, 0, 1, 8),
            ei(OPC_OPIMM, 0, 1, 0, 5), es(2, 1, 0, 32'h124));

        // Reset values, first request and 4-cycle ALU retirement
        rst_n = 1'b0;
        bus.i_wb_stb = 1'b1;
        load_mem(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst stb", 32'(bus.o_wb_stb), 32'd0);
        chk("rst we", 32'(bus.o_wb_we), 32'd0);
        chk("rst ack", 32'(bus.o_wb_ack), 32'd0);
        chk("rst addr", bus.o_wb_addr, 32'h0);
        chk("rst data", bus.o_wb_data, 32'h0);
        chk("rst sel", 32'(bus.o_wb_sel), 32'(SEL_WORD));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release stb", 32'(bus.o_wb_stb), 32'd0);
        @(posedge clk); #1;
        chk("first stb", 32'(bus.o_wb_stb), 32'd1);
        chk("first addr", bus.o_wb_addr, 32'h0);
        chk("first sel", 32'(bus.o_wb_sel), 32'(SEL_WORD));
        chk("first we", 32'(bus.o_wb_we), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("alu retire", 32'(bus.o_wb_ack), 32'd1);
        @(posedge clk); #1;
        chk("retire pulse", 32'(bus.o_wb_ack), 32'd0);
        chk("second stb", 32'(bus.o_wb_stb), 32'd1);
        chk("second addr", bus.o_wb_addr, 32'h4);

        foreach (vecs[i]) begin
            reset_release(vecs[i], 1'b0);
            run_check(vecs[i]);
        end

        // Stall held three cycles on the first fetch
        reset_release(vecs[0], 1'b1);
        cyc = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("stall stb", 32'(bus.o_wb_stb), 32'd1);
            chk("stall addr", bus.o_wb_addr, 32'h0);
        end
        bus.i_wb_stall = 1'b0;
        @(posedge clk); #1;
        chk("stall drop", 32'(bus.o_wb_stb), 32'd0);
        chk("stall accepts", 32'(acc_cnt - cyc), 32'd1);
        run_check(vecs[0]);

        // Async reset while a load request is held by stall
        add("restart", 32'h124, 32'hDEAD_BEEF, SEL_WORD, 1,
            ei(OPC_LOAD, 2, 3, 0, 32'h204), es(2, 3, 0, 32'h124));
        vd = vecs[vecs.size() - 1];
        reset_release(vd, 1'b0);
        cyc = 0;
        while (!(bus.o_wb_stb && bus.o_wb_addr == 32'h204) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mem stb seen", 32'(bus.o_wb_stb), 32'd1);
        bus.i_wb_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async stb", 32'(bus.o_wb_stb), 32'd0);
        chk("async addr", bus.o_wb_addr, 32'h0);

        // Reset in MEM_WAIT with the ack pending, then restart from 0
        reset_release(vd, 1'b0);
        cyc = 0;
        while (!(bus.o_wb_stb && bus.o_wb_addr == 32'h204) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        chk("wait ack pending", 32'(bus.i_wb_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wait rst stb", 32'(bus.o_wb_stb), 32'd0);
        chk("wait rst ack", 32'(bus.o_wb_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart stb", 32'(bus.o_wb_stb), 32'd1);
        chk("restart addr", bus.o_wb_addr, 32'h0);
        run_check(vd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_wb_core.md
# rv32i_wb_core

Multicycle RV32I integer core with a single pipelined-Wishbone master port used for both instruction fetch and data access. It sits between the system reset/clock and a Wishbone slave memory that holds code and data in one flat 32-bit byte-addressed space. It executes one instruction at a time and signals retirement on a status strobe.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- XLEN, 32, register and bus width (fixed; not overridable in practice)

Ports:
- i_clk  in  1  single clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset; clears state the instant it is low
- i_wb_stb  in  1  run enable; core starts a new fetch only while high
- i_wb_ack  in  1  slave ack, one cycle per accepted request
- i_wb_stall  in  1  slave stall; request not accepted while high
- i_wb_data  in  32  read data, valid with i_wb_ack, right-aligned, zero-extended
- o_wb_data  out  32  write data, right-aligned (byte in [7:0], half in [15:0])
- o_wb_addr  out  32  byte address
- o_wb_we  out  1  1 = store, 0 = fetch/load
- o_wb_stb  out  1  request strobe
- o_wb_sel  out  3  access size: 3'b000 byte, 3'b001 half, 3'b010 word (fetches always 010)
- o_wb_ack  out  1  one-cycle pulse per retired instruction

## Operation
- States: FETCH, FETCH_WAIT, EXECUTE, MEM, MEM_WAIT, WRITEBACK.
- FETCH: drive stb=1, we=0, addr=pc, sel=010. Exit when stb && !stall; then FETCH_WAIT.
- FETCH_WAIT: on ack latch instruction into ir → EXECUTE.
- EXECUTE: decode; compute ALU result, branch target, next pc. Loads/stores → MEM; all else → WRITEBACK.
- MEM: address = rs1 + imm_s/imm_i; sel = funct3[1:0]; store drives we=1, data = rs2. Exit on acceptance → MEM_WAIT.
- MEM_WAIT: on ack → WRITEBACK. Loads sign-extend per funct3 (LB/LH sign, LBU/LHU zero, LW none).
- WRITEBACK: write rd (writes to x0 discarded), pc ← next pc, pulse o_wb_ack, → FETCH.
- Supported: LUI, AUIPC, JAL, JALR (target & ~1), BEQ/BNE/BLT/BGE/BLTU/BGEU, all loads/stores, OP-IMM, OP incl. SUB/SRA/SRAI. Shifts use low 5 bits.
- FENCE, SYSTEM, and unknown opcodes retire as NOP (pc+4).
- Misaligned addresses are issued unchanged; no trap.
- Arithmetic mod 2^32; slt/sltu per ISA.

## Timing
- Reset (i_reset low): pc=RESET_PC, state=FETCH, o_wb_stb=0, o_wb_we=0, o_wb_ack=0, o_wb_addr=0, o_wb_data=0, o_wb_sel=010; registers x1..x31 cleared to 0.
- First o_wb_stb rises on the first clock edge after reset deassertion with i_wb_stb high.
- Strobe held and addr/data/sel/we stable while stall high; stb drops the cycle after acceptance.
- At most one outstanding request; ack outside a WAIT state is ignored.
- Ack in the same cycle as acceptance is not assumed; ack arrives ≥1 cycle after acceptance.
- Minimum latency per instruction: ALU 4 cycles, load/store 6 cycles, with zero-stall one-cycle-ack memory.
- Reset asserted mid-transaction: stb drops immediately; the pending ack is discarded.
- i_wb_stb low: core completes the current instruction, then idles in FETCH with stb=0.

## Structure
- Shared package: opcode constants, funct3 size codes (SEL_BYTE/HALF/WORD), state enum, ALU op enum.
- One natural sub-module: rv32i_alu (combinational, op + two 32-bit operands → 32-bit result, plus compare flags for branches).
- Register file inline: 31×32 array, two async reads.

## Test plan
- Reset release → first request addr=0x0, sel=010, we=0, stb high one cycle later.
- ADDI x1,x0,5; ADDI x2,x1,-3; SW x2,0x100(x0) → store addr 0x100, data 0x2, sel 010, we=1; three o_wb_ack pulses.
- Memory byte 0x80 at 0x200; LB x3,0x200(x0) then SW x3 → written word 0xFFFF_FF80; LBU gives 0x0000_0080.
- JAL x1,+8 at 0x10 → x1=0x14, next fetch 0x18; BEQ taken/not-taken select target/pc+4.
- i_wb_stall high 3 cycles during fetch → stb, addr held constant; one request accepted.
- ADDI x0,x0,7 then read x0 via SW → stores 0; reset low mid-MEM_WAIT → stb=0 at once, fetch restarts at 0x0.
